writeback_stage: RTL and testbench

//  Final stage of the 16-bit execute pipeline. Accepts one ALU result per cycle with its flags and decoded

---
 rtl/writeback_stage_if.sv | 43 ++++
 rtl/writeback_stage.sv | 136 +++++++++++++
 tb/tb_writeback_stage.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Writeback stage bus: instruction handshake from the ALU, register-file write port,
// architectural status, branch redirect and the OUT display stream.
interface writeback_stage_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [3:0]        in_op;
  logic [DATA_W-1:0] in_result;
  logic              in_v;
  logic              in_z;
  logic              in_c;
  logic              in_s;
  logic [2:0]        in_rd;
  logic [2:0]        in_cond;
  logic [DATA_W-1:0] in_target;
  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [3:0]        flags;
  logic              br_taken;
  logic [DATA_W-1:0] br_pc;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              halted;
  logic [31:0]       retired;

  modport master (
    output in_valid, in_kind, in_op, in_result, in_v, in_z, in_c, in_s,
           in_rd, in_cond, in_target, out_ready,
    input  in_ready, rf_we, rf_waddr, rf_wdata, flags, br_taken, br_pc,
           out_valid, out_data, halted, retired
  );

  modport slave (
    input  in_valid, in_kind, in_op, in_result, in_v, in_z, in_c, in_s,
           in_rd, in_cond, in_target, out_ready,
    output in_ready, rf_we, rf_waddr, rf_wdata, flags, br_taken, br_pc,
           out_valid, out_data, halted, retired
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: register-file write, SZCV flags, branch resolve, OUT FIFO and HALT latch.
// Define RETIRE_COUNT_EN to build the retired-instruction counter; otherwise retired reads 0.
module writeback_stage #(
  parameter int DATA_W    = 16,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  writeback_stage_if.slave wb
);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0] KIND_ALU  = 3'd0;
  localparam logic [2:0] KIND_OUT  = 3'd1;
  localparam logic [2:0] KIND_BR   = 3'd2;
  localparam logic [2:0] KIND_HALT = 3'd3;

  logic [DATA_W-1:0] fifo_q [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [2:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [3:0]        flags_q, flags_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_pc_q, br_pc_d;
  logic              halted_q, halted_d;
  logic              in_ready, accept, push, pop, is_alu, rf_wr, flag_wr, cond_met;
  logic              flag_s, flag_z, flag_v;

  assign flag_s = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_v = flags_q[0];

  always_comb begin
    pop      = (cnt_q != '0) & wb.out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    in_ready = ~halted_q & ~br_taken_q & ~((cnt_q == CNT_W'(OUT_DEPTH)) & ~pop);
    accept   = wb.in_valid & in_ready;
    push     = accept & (wb.in_kind == KIND_OUT);
    is_alu   = accept & (wb.in_kind == KIND_ALU);
    rf_wr    = wb.in_op inside {[4'd0:4'd4], 4'd6, [4'd8:4'd12]};
    flag_wr  = wb.in_op inside {[4'd0:4'd6], [4'd8:4'd11]};

    case (wb.in_cond)
      3'd0:    cond_met = flag_z;
      3'd1:    cond_met = flag_s ^ flag_v;
      3'd2:    cond_met = flag_z | (flag_s ^ flag_v);
      3'd3:    cond_met = ~flag_z;
      3'd7:    cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase

    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    flags_d    = flags_q;
    br_pc_d    = br_pc_q;
    halted_d   = halted_q;

    rf_we_d = is_alu & rf_wr;
    if (rf_we_d) begin
      rf_waddr_d = wb.in_rd;
      rf_wdata_d = wb.in_result;
    end
    // Incoming in_s is the non-negative sense; the architectural S bit means negative.
    if (is_alu & flag_wr) flags_d = {~wb.in_s, wb.in_z, wb.in_c, wb.in_v};

    br_taken_d = accept & (wb.in_kind == KIND_BR) & cond_met;
    if (br_taken_d) br_pc_d = wb.in_target;
    if (accept & (wb.in_kind == KIND_HALT)) halted_d = 1'b1;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      flags_q    <= '0;
      br_taken_q <= 1'b0;
      br_pc_q    <= '0;
      halted_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      flags_q    <= flags_d;
      br_taken_q <= br_taken_d;
      br_pc_q    <= br_pc_d;
      halted_q   <= halted_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < OUT_DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= wb.in_result;
    end
  end

`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_q, retired_d;

  assign retired_d = accept ? retired_q + 32'd1 : retired_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign wb.retired = retired_q;
`else
  assign wb.retired = 32'd0;
`endif

  assign wb.in_ready  = in_ready;
  assign wb.rf_we     = rf_we_q;
  assign wb.rf_waddr  = rf_waddr_q;
  assign wb.rf_wdata  = rf_wdata_q;
  assign wb.flags     = flags_q;
  assign wb.br_taken  = br_taken_q;
  assign wb.br_pc     = br_pc_q;
  assign wb.out_valid = (cnt_q != '0);
  assign wb.out_data  = (cnt_q != '0) ? fifo_q[rd_ptr_q] : '0;
  assign wb.halted    = halted_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: a driver derives expected effects from an instruction-level
// model and queues them; a monitor pops and compares whenever the stage presents an output.
module tb_writeback_stage;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;
  localparam logic [2:0] K_ALU = 3'd0, K_OUT = 3'd1, K_BR = 3'd2, K_HALT = 3'd3, K_NOP = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_stage_if #(.DATA_W(DATA_W)) bus ();

  writeback_stage #(.DATA_W(DATA_W), .OUT_DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .wb   (bus)
  );

  typedef struct { int edge_n; logic [2:0] addr; logic [15:0] data; } rf_rec_t;
  typedef struct { int edge_n; logic [15:0] pc; } br_rec_t;
  typedef struct { int edge_n; logic [3:0] flags; logic halted; logic [31:0] retired; } st_rec_t;

  rf_rec_t     rf_q[$];
  br_rec_t     br_q[$];
  st_rec_t     st_q[$];
  logic [15:0] out_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit chk_en      = 1'b0;

  logic [3:0]  m_flags;
  logic        m_halted, m_br;
  int          m_cnt;
  logic [31:0] m_retired;

  rf_rec_t mr;
  br_rec_t mb;
  st_rec_t ms;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ret_exp();
`ifdef RETIRE_COUNT_EN
    return m_retired;
`else
    return 32'd0;
`endif
  endfunction

  // S means negative; "less than" holds when the sign disagrees with overflow.
  function automatic logic branch_taken(input logic [2:0] cond, input logic [3:0] f);
    logic neg, zero, ovf, less;
    neg  = f[3];
    zero = f[2];
    ovf  = f[0];
    less = (neg != ovf);
    case (cond)
      3'd0:    return zero;
      3'd1:    return less;
      3'd2:    return zero || less;
      3'd3:    return !zero;
      3'd7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: registered effects checked 2 units after each edge, FIFO head 3 units after.
  initial forever begin
    @(posedge clk);
    cyc++;
    #2;
    if (chk_en) begin
      if (bus.rf_we) begin
        if (rf_q.size() == 0 || rf_q[0].edge_n != cyc) chk("rf_we_spurious", 32'(bus.rf_we), 32'd0);
        else begin
          mr = rf_q.pop_front();
          chk("rf_waddr", 32'(bus.rf_waddr), 32'(mr.addr));
          chk("rf_wdata", 32'(bus.rf_wdata), 32'(mr.data));
        end
      end else if (rf_q.size() != 0 && rf_q[0].edge_n == cyc) begin
        mr = rf_q.pop_front();
        chk("rf_we_missing", 32'(bus.rf_we), 32'd1);
      end
      if (bus.br_taken) begin
        if (br_q.size() == 0 || br_q[0].edge_n != cyc) chk("br_taken_spurious", 32'(bus.br_taken), 32'd0);
        else begin
          mb = br_q.pop_front();
          chk("br_pc", 32'(bus.br_pc), 32'(mb.pc));
        end
      end else if (br_q.size() != 0 && br_q[0].edge_n == cyc) begin
        mb = br_q.pop_front();
        chk("br_taken_missing", 32'(bus.br_taken), 32'd1);
      end
      if (st_q.size() != 0 && st_q[0].edge_n == cyc) begin
        ms = st_q.pop_front();
        chk("flags", 32'(bus.flags), 32'(ms.flags));
        chk("halted", 32'(bus.halted), 32'(ms.halted));
        chk("retired", bus.retired, ms.retired);
      end
    end
    #1;
    if (chk_en) begin
      chk("out_valid", 32'(bus.out_valid), 32'(out_q.size() != 0));
      if (bus.out_valid && bus.out_ready && out_q.size() != 0)
        chk("out_data", 32'(bus.out_data), 32'(out_q.pop_front()));
    end
  end

  task automatic step(input logic v, input logic [2:0] kind, input logic [3:0] op,
                      input logic [15:0] res, input logic fv, input logic fz, input logic fc,
                      input logic fs, input logic [2:0] rd, input logic [2:0] cond,
                      input logic [15:0] tgt, input logic ordy);
    logic rdy_m, acc, taken, pop_m;
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_kind   = kind;
    bus.in_op     = op;
    bus.in_result = res;
    bus.in_v      = fv;
    bus.in_z      = fz;
    bus.in_c      = fc;
    bus.in_s      = fs;
    bus.in_rd     = rd;
    bus.in_cond   = cond;
    bus.in_target = tgt;
    bus.out_ready = ordy;
    #3;
    pop_m = (m_cnt > 0) && ordy;
    rdy_m = !m_halted && !m_br && !(m_cnt == DEPTH && !pop_m);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy_m));
    acc   = v && rdy_m;
    taken = 1'b0;
    if (acc) begin
      m_retired = m_retired + 32'd1;
      case (kind)
        K_ALU: begin
          if (op inside {[4'd0:4'd4], 4'd6, [4'd8:4'd12]})
            rf_q.push_back('{edge_n: cyc + 1, addr: rd, data: res});
          if (op inside {[4'd0:4'd6], [4'd8:4'd11]}) m_flags = {!fs, fz, fc, fv};
        end
        K_OUT: begin
          out_q.push_back(res);
          m_cnt++;
        end
        K_BR: begin
          taken = branch_taken(cond, m_flags);
          if (taken) br_q.push_back('{edge_n: cyc + 1, pc: tgt});
        end
        K_HALT: m_halted = 1'b1;
        default: ;
      endcase
    end
    if (pop_m) m_cnt--;
    m_br = taken;
    st_q.push_back('{edge_n: cyc + 1, flags: m_flags, halted: m_halted, retired: ret_exp()});
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, K_NOP, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0, ordy);
  endtask

  task automatic alu(input logic [3:0] op, input logic [15:0] res, input logic fv, input logic fz,
                     input logic fc, input logic fs, input logic [2:0] rd);
    step(1'b1, K_ALU, op, res, fv, fz, fc, fs, rd, 3'd0, 16'd0, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b1;
    chk_en        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rf_q.delete();
    br_q.delete();
    st_q.delete();
    out_q.delete();
    m_flags   = 4'd0;
    m_halted  = 1'b0;
    m_br      = 1'b0;
    m_cnt     = 0;
    m_retired = 32'd0;
    chk("rst_flags", 32'(bus.flags), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_retired", bus.retired, 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_br_taken", 32'(bus.br_taken), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_kind   = K_NOP;
    bus.in_op     = 4'd0;
    bus.in_result = 16'd0;
    bus.in_v      = 1'b0;
    bus.in_z      = 1'b0;
    bus.in_c      = 1'b0;
    bus.in_s      = 1'b0;
    bus.in_rd     = 3'd0;
    bus.in_cond   = 3'd0;
    bus.in_target = 16'd0;
    bus.out_ready = 1'b0;
    do_reset();

    // ADD with negative result and overflow
    alu(4'd0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    idle(1'b1);

    // CMP sets Z without a write, BE taken, next presented instruction squashed
    alu(4'd5, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5);
    step(1'b1, K_BR, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0040, 1'b1);
    alu(4'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    idle(1'b1);

    // S=1 V=0 Z=1: BLT taken, BNE not taken
    alu(4'd1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
    step(1'b1, K_BR, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 16'h0100, 1'b1);
    step(1'b1, K_NOP, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0, 1'b1);
    step(1'b1, K_BR, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 16'h0200, 1'b1);
    idle(1'b1);

    // OUT FIFO fills, third waits, then enters on the first pop
    step(1'b1, K_OUT, 4'd0, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0, 1'b0);
    step(1'b1, K_OUT, 4'd0, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0, 1'b0);
    step(1'b1, K_OUT, 4'd0, 16'h0033, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0, 1'b0);
    step(1'b1, K_OUT, 4'd0, 16'h0033, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Randomized traffic, HALT excluded so the stage keeps running
    for (int i = 0; i < 600; i++) begin
      logic [2:0] k;
      k = 3'($urandom_range(0, 7));
      if (k == K_HALT) k = K_NOP;
      step(($urandom_range(0, 9) < 8), k, 4'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
           3'($urandom), 16'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    // HALT with a full FIFO: nothing else accepted, FIFO still drains
    step(1'b1, K_OUT, 4'd0, 16'h00A1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0, 1'b0);
    step(1'b1, K_OUT, 4'd0, 16'h00A2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0, 1'b0);
    step(1'b1, K_HALT, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0, 1'b1);
    for (int i = 0; i < 6; i++) alu(4'd0, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("halted_sticky", 32'(bus.halted), 32'd1);
    do_reset();

    // After reset the stage is live again
    alu(4'd2, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
    step(1'b1, K_BR, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd7, 16'h0ABC, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
